// File: rtl/fixed_point_iterative_pkg.sv
// rtl/fixed_point_iterative_pkg.sv - shared state encodings and saturation helper for fixed-point iterative blocks
package fixed_point_iterative_pkg;

  // Compute sequence of the complex multiplier, one state per real product
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AABB = 2'd1,
    ARBR = 2'd2,
    ACBC = 2'd3
  } cmul_state_e;

  // Shared shift-add multiplier sequence
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_CALC = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Working width of the clamp helper; callers sign-extend into it
  localparam int SAT_W = 128;

  // Clamp a signed value into the two's complement range of a w-bit word
  function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v,
                                                        input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed(({{(SAT_W-1){1'b0}}, 1'b1} << (w - 1)) - {{(SAT_W-1){1'b0}}, 1'b1});
    lo = ~hi;
    if (v > hi) begin
      sat_clamp = hi;
    end else if (v < lo) begin
      sat_clamp = lo;
    end else begin
      sat_clamp = v;
    end
  endfunction

endpackage

// File: rtl/fixed_point_iterative_Multiplier.sv
// rtl/fixed_point_iterative_Multiplier.sv - iterative signed fixed-point multiplier, one partial product per cycle
module fixed_point_iterative_Multiplier
  import fixed_point_iterative_pkg::*;
#(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c
);

  localparam int CNT_W = (n > 2) ? $clog2(n) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(n - 1);

  mul_state_e       state_q, state_d;
  logic [2*n-1:0]   acc_q, acc_d;
  logic [2*n-1:0]   mcand_q, mcand_d;
  logic [n-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_acc_bits;

  // Shift-add sequence; the MSB of the multiplier has negative weight, so its partial product is subtracted
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (recv_val) begin
          acc_d    = '0;
          mcand_d  = {{n{a[n-1]}}, a};
          mplier_d = b;
          cnt_d    = '0;
          state_d  = MUL_CALC;
        end
      end
      MUL_CALC: begin
        if (mplier_q[0]) begin
          acc_d = (cnt_q == LAST) ? (acc_q - mcand_q) : (acc_q + mcand_q);
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (send_rdy) begin
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // Multiplier state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MUL_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign recv_rdy = (state_q == MUL_IDLE);
  assign send_val = (state_q == MUL_DONE);
  // Dropping d fraction LSBs of the exact product floors it; keeping n bits above wraps it
  assign c        = acc_q[d +: n];
  assign unused_acc_bits = ^{acc_q[d-1:0], acc_q[2*n-1:d+n]};

endmodule

// File: rtl/fixed_point_iterative_complex_multiplier_mode.sv
// rtl/fixed_point_iterative_complex_multiplier_mode.sv - complex multiply (optionally by conjugate) over one shared iterative multiplier
module fixed_point_iterative_complex_multiplier_mode
  import fixed_point_iterative_pkg::*;
#(
  parameter int n   = 32,
  parameter int d   = 16,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  input  logic         conj,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc
);

  localparam int CW = n + 2;

  cmul_state_e state_q, state_d;
  logic [n-1:0] ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
  logic [n-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic [n-1:0] cr_q, cr_d, cc_q, cc_d;
  logic         p2_done_q, p2_done_d;
  logic         res_valid_q, res_valid_d;

  logic         mul_recv_val, mul_recv_rdy_unused, mul_send_val;
  logic [n-1:0] mul_a, mul_b, mul_c;

  logic [n-1:0]            p2_now;
  logic signed [CW-1:0]    p0_x, p1_x, p2_x, cr_w, cc_w;
  logic signed [SAT_W-1:0] cr_clamp, cc_clamp;
  logic [n-1:0]            cr_next, cc_next;
  logic                    acbc_done, res_free, send_fire;
  logic                    unused_clamp_bits;

  // Operand pair fed to the shared multiplier in each product state (pre-adds wrap at n bits)
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      AABB: begin
        mul_a = ar_q + ac_q;
        mul_b = br_q + bc_q;
      end
      ARBR: begin
        mul_a = ar_q;
        mul_b = br_q;
      end
      ACBC: begin
        mul_a = ac_q;
        mul_b = bc_q;
      end
      default: ;
    endcase
  end

  // A parked P2 must not launch another multiplication while waiting for the result register
  assign mul_recv_val = (state_q != IDLE) && !p2_done_q;

  fixed_point_iterative_Multiplier #(
    .n (n),
    .d (d)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .recv_val (mul_recv_val),
    .recv_rdy (mul_recv_rdy_unused),
    .a        (mul_a),
    .b        (mul_b),
    .send_val (mul_send_val),
    .send_rdy (1'b1),
    .c        (mul_c)
  );

  // Final combine at n+2 bits so neither difference can overflow before wrap or clamp
  always_comb begin
    p2_now   = p2_done_q ? p2_q : mul_c;
    p0_x     = $signed({{2{p0_q[n-1]}}, p0_q});
    p1_x     = $signed({{2{p1_q[n-1]}}, p1_q});
    p2_x     = $signed({{2{p2_now[n-1]}}, p2_now});
    cr_w     = p1_x - p2_x;
    cc_w     = p0_x - p1_x - p2_x;
    cr_clamp = sat_clamp($signed({{(SAT_W-CW){cr_w[CW-1]}}, cr_w}), n);
    cc_clamp = sat_clamp($signed({{(SAT_W-CW){cc_w[CW-1]}}, cc_w}), n);
    cr_next  = (SAT != 0) ? cr_clamp[n-1:0] : cr_w[n-1:0];
    cc_next  = (SAT != 0) ? cc_clamp[n-1:0] : cc_w[n-1:0];
  end

  assign unused_clamp_bits = ^{cr_clamp[SAT_W-1:n], cc_clamp[SAT_W-1:n]};

  assign send_fire = res_valid_q && send_rdy;
  assign res_free  = !res_valid_q || send_rdy;
  assign acbc_done = (state_q == ACBC) && (mul_send_val || p2_done_q);

  // Compute sequence and result register; a draining result frees the register in the same cycle
  always_comb begin
    state_d     = state_q;
    ar_d        = ar_q;
    ac_d        = ac_q;
    br_d        = br_q;
    bc_d        = bc_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p2_done_d   = p2_done_q;
    cr_d        = cr_q;
    cc_d        = cc_q;
    res_valid_d = send_fire ? 1'b0 : res_valid_q;
    case (state_q)
      IDLE: begin
        if (recv_val) begin
          ar_d    = ar;
          ac_d    = ac;
          br_d    = br;
          bc_d    = conj ? -bc : bc;
          state_d = AABB;
        end
      end
      AABB: begin
        if (mul_send_val) begin
          p0_d    = mul_c;
          state_d = ARBR;
        end
      end
      ARBR: begin
        if (mul_send_val) begin
          p1_d    = mul_c;
          state_d = ACBC;
        end
      end
      ACBC: begin
        if (acbc_done) begin
          if (res_free) begin
            cr_d        = cr_next;
            cc_d        = cc_next;
            res_valid_d = 1'b1;
            p2_done_d   = 1'b0;
            state_d     = IDLE;
          end else if (!p2_done_q) begin
            p2_d      = mul_c;
            p2_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Top-level state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ar_q        <= '0;
      ac_q        <= '0;
      br_q        <= '0;
      bc_q        <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p2_done_q   <= 1'b0;
      cr_q        <= '0;
      cc_q        <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ar_q        <= ar_d;
      ac_q        <= ac_d;
      br_q        <= br_d;
      bc_q        <= bc_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p2_done_q   <= p2_done_d;
      cr_q        <= cr_d;
      cc_q        <= cc_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign recv_rdy = (state_q == IDLE);
  assign send_val = res_valid_q;
  assign cr       = cr_q;
  assign cc       = cc_q;

endmodule
